// File: rtl/result_fraction_select_stage.sv
// Picks the stored fraction field from zero/qNaN/operand/result sources, registered.
// Define RESULT_FRACTION_SELECT_SKID_EN for a 2-entry stage with registered in_ready.
module result_fraction_select_stage #(
    parameter int FRAC_WIDTH   = 23,
    parameter int RESULT_WIDTH = FRAC_WIDTH + 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              fraction_select,
    input  logic [FRAC_WIDTH:0]     operand_fraction_a,
    input  logic [FRAC_WIDTH:0]     operand_fraction_b,
    input  logic [RESULT_WIDTH-1:0] result_fraction,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FRAC_WIDTH-1:0]   out_fraction
);

    localparam int W = FRAC_WIDTH;
    localparam int R = RESULT_WIDTH;

    localparam logic [2:0] SEL_ZERO    = 3'd0;
    localparam logic [2:0] SEL_QNAN    = 3'd1;
    localparam logic [2:0] SEL_A       = 3'd2;
    localparam logic [2:0] SEL_B       = 3'd3;
    localparam logic [2:0] SEL_RESULT  = 3'd4;
    localparam logic [2:0] SEL_IRESULT = 3'd5;

    logic [W-1:0] w_sel;
    logic         w_push;
    logic         w_pop;
    logic         w_unused;
    logic         r_valid;
    logic [W-1:0] r_frac;

    // Hidden bits and result bits outside the selected windows are don't-care.
    assign w_unused = ^{operand_fraction_a[W], operand_fraction_b[W],
                        result_fraction};

    always_comb begin
        w_sel = '0;
        case (fraction_select)
            SEL_ZERO:    w_sel = '0;
            SEL_QNAN:    w_sel[W-1] = 1'b1;
            SEL_A:       w_sel = operand_fraction_a[W-1:0];
            SEL_B:       w_sel = operand_fraction_b[W-1:0];
            SEL_RESULT:  w_sel = result_fraction[R-3 -: W];
            SEL_IRESULT: w_sel = result_fraction[W-1:0];
            default:     w_sel = '0;
        endcase
    end

    assign w_push       = in_valid && in_ready;
    assign w_pop        = r_valid && out_ready;
    assign out_valid    = r_valid;
    assign out_fraction = r_frac;

`ifdef RESULT_FRACTION_SELECT_SKID_EN

    logic         r_skid_valid;
    logic [W-1:0] r_skid_frac;

    // Ready depends only on the skid flag, never on out_ready.
    assign in_ready = !r_skid_valid && !reset && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_frac       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_frac  <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_valid || w_pop) begin
            if (r_skid_valid) begin
                r_valid      <= 1'b1;
                r_frac       <= r_skid_frac;
                r_skid_valid <= 1'b0;
            end else if (w_push) begin
                r_valid <= 1'b1;
                r_frac  <= w_sel;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_skid_valid <= 1'b1;
            r_skid_frac  <= w_sel;
        end
    end

`else

    assign in_ready = (!r_valid || out_ready) && !reset && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_frac  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_push) begin
            r_valid <= 1'b1;
            r_frac  <= w_sel;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_result_fraction_select_stage.sv
// Directed bench for result_fraction_select_stage, W=23 R=32.
// Works with either build; capacity follows RESULT_FRACTION_SELECT_SKID_EN.
module tb_result_fraction_select_stage;

`ifdef RESULT_FRACTION_SELECT_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fraction_select;
    logic [23:0] operand_fraction_a;
    logic [23:0] operand_fraction_b;
    logic [31:0] result_fraction;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_fraction;

    int          tests = 0;
    int          fails = 0;
    int          npop  = 0;
    int          k;
    int          base;
    int          bubbles;
    logic        acc;
    logic [22:0] expq[$];
    logic [23:0] hv[3];

    always #5 clk = ~clk;

    result_fraction_select_stage #(
        .FRAC_WIDTH(23),
        .RESULT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .fraction_select(fraction_select),
        .operand_fraction_a(operand_fraction_a),
        .operand_fraction_b(operand_fraction_b),
        .result_fraction(result_fraction),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_fraction(out_fraction)
    );

    function automatic logic [22:0] ref_sel(input logic [2:0] c,
                                            input logic [23:0] a,
                                            input logic [23:0] b,
                                            input logic [31:0] r);
        case (c)
            3'd1:    return 23'h400000;
            3'd2:    return a[22:0];
            3'd3:    return b[22:0];
            3'd4:    return r[29:7];
            3'd5:    return r[22:0];
            default: return 23'h000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] c, input logic [23:0] a,
                         input logic [23:0] b, input logic [31:0] r);
        fraction_select    = c;
        operand_fraction_a = a;
        operand_fraction_b = b;
        result_fraction    = r;
    endtask

    // Scoreboard: record accepted beats, compare every popped beat in order.
    task automatic tick();
        logic [22:0] e;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc)
            expq.push_back(ref_sel(fraction_select, operand_fraction_a,
                                   operand_fraction_b, result_fraction));
        if (out_valid && out_ready) begin
            npop++;
            if (expq.size() == 0) begin
                chk("stale_pop", 32'(out_valid), 32'd0);
            end else begin
                e = expq.pop_front();
                chk("pop_order", 32'(out_fraction), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(3'd0, 24'h0, 24'h0, 32'h0);
        hv[0] = 24'h000011;
        hv[1] = 24'h000022;
        hv[2] = 24'h000033;

        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_frac", 32'(out_fraction), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        drive(3'd0, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF);
        tick();
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero", 32'(out_fraction), 32'h000000);
        drive(3'd1, 24'h0, 24'h0, 32'h0);
        tick();
        chk("qnan", 32'(out_fraction), 32'h400000);
        drive(3'd5, 24'h0, 24'h0, 32'h00555555);
        tick();
        chk("iresult", 32'(out_fraction), 32'h555555);
        drive(3'd4, 24'h0, 24'h0, 32'h3FFFFFFF);
        tick();
        chk("result_max", 32'(out_fraction), 32'h7FFFFF);
        drive(3'd2, 24'hC00001, 24'h0, 32'h0);
        tick();
        chk("opa", 32'(out_fraction), 32'h400001);
        drive(3'd6, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF);
        tick();
        chk("code6", 32'(out_fraction), 32'h000000);
        drive(3'd7, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFF);
        tick();
        chk("code7", 32'(out_fraction), 32'h000000);
        drive(3'd3, 24'h0, 24'h923456, 32'h0);
        tick();
        chk("opb", 32'(out_fraction), 32'h123456);
        drive(3'd4, 24'h0, 24'h0, 32'h00000080);
        tick();
        chk("result_lsb", 32'(out_fraction), 32'h000001);
        in_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: three cycles of out_ready=0 with a waiting upstream.
        base      = npop;
        k         = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd2, hv[0], 24'h0, 32'h0);
        chk("hold_rdy0", 32'(in_ready), 32'd1);
        tick();
        if (acc) k++;
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_frac0", 32'(out_fraction), 32'h000011);
        drive(3'd2, hv[k], 24'h0, 32'h0);
        chk("hold_rdy1", 32'(in_ready), (CAP > 1) ? 32'd1 : 32'd0);
        tick();
        if (acc) k++;
        chk("hold_frac1", 32'(out_fraction), 32'h000011);
        drive(3'd2, hv[k], 24'h0, 32'h0);
        chk("hold_rdy2", 32'(in_ready), 32'd0);
        tick();
        if (acc) k++;
        chk("hold_frac2", 32'(out_fraction), 32'h000011);
        chk("hold_accepts", 32'(k), 32'(CAP));
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (k < 3) drive(3'd2, hv[k], 24'h0, 32'h0);
            else in_valid = 1'b0;
            tick();
            if (acc) k++;
        end
        chk("hold_all_in", 32'(k), 32'd3);
        chk("hold_pops", 32'(npop - base), 32'd3);
        chk("hold_drained", 32'(out_valid), 32'd0);

        // Full-throughput stream.
        base     = npop;
        bubbles  = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(3'($urandom_range(0, 7)), 24'($urandom),
                  24'($urandom), $urandom);
            tick();
            if (!acc) bubbles++;
            if (!out_valid) bubbles++;
        end
        in_valid = 1'b0;
        tick();
        chk("stream_pops", 32'(npop - base), 32'd100);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_empty", 32'(expq.size()), 32'd0);

        // Flush with the stage full and a beat on the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd2, 24'h000077, 24'h0, 32'h0);
        for (int c = 0; c < 4; c++) tick();
        chk("fl_full_rdy", 32'(in_ready), 32'd0);
        base  = npop;
        flush = 1'b1;
        #1;
        chk("fl_rdy", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        expq.delete();
        chk("fl_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        #1;
        chk("fl_rdy_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_beat", 32'(npop - base), 32'd0);

        // Reset while a beat is held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(3'd2, 24'h5A5A5A, 24'h0, 32'h0);
        tick();
        chk("rs_held", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rs_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_frac", 32'(out_fraction), 32'd0);
        expq.delete();
        base      = npop;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rs_no_stale", 32'(npop - base), 32'd0);
        chk("rs_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_fraction_select_stage.md
RESULT_FRACTION_SELECT_STAGE -- requirements
Module: result_fraction_select_stage

Interface
REQ-001 Parameter FRAC_WIDTH, default 23, SHALL be the stored fraction field width W (23 single, 52 double); legal range 4..52.
REQ-002 Parameter RESULT_WIDTH, default FRAC_WIDTH+9, SHALL be the result datapath width R in [xx.xxxx...] format (2 integer bits); legal when R >= W+2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 flush  input  1  SHALL synchronously discard all held entries.
REQ-006 in_valid  input  1  SHALL mark the upstream beat as valid.
REQ-007 in_ready  output  1  SHALL indicate that a beat is accepted this cycle.
REQ-008 fraction_select  input  3  SHALL be the source code: 0 ZERO, 1 QNAN, 2 A, 3 B, 4 RESULT, 5 IRESULT; 6 and 7 reserved.
REQ-009 operand_fraction_a, operand_fraction_b  input  W+1 each  SHALL carry significands with the hidden bit at [W].
REQ-010 result_fraction  input  R  SHALL carry the arithmetic result.
REQ-011 out_valid  output  1  SHALL mark out_fraction as valid.
REQ-012 out_ready  input  1  SHALL indicate downstream acceptance.
REQ-013 out_fraction  output  W  SHALL be the selected stored fraction field.

Function
REQ-014 A beat SHALL transfer in when in_valid && in_ready; it SHALL transfer out when out_valid && out_ready.
REQ-015 Selection SHALL be: ZERO -> all 0; QNAN -> bit W-1 = 1, rest 0; A -> a[W-1:0]; B -> b[W-1:0]; RESULT -> result_fraction[R-3 -: W]; IRESULT -> result_fraction[W-1:0]; reserved codes -> all 0.
REQ-016 Selection SHALL be evaluated on the accepted beat and registered; out_fraction SHALL come from flops only.
REQ-017 Latency SHALL be exactly 1 cycle from acceptance to out_valid when the stage is empty.
REQ-018 Beats SHALL leave in acceptance order, with none dropped or duplicated, except under flush or reset.
REQ-019 While out_valid=1 and out_ready=0, out_fraction SHALL hold stable.
REQ-020 flush SHALL clear all valid flags next cycle; in_ready SHALL be 0 during a flush cycle; a beat presented with flush SHALL be discarded.
REQ-021 Full-throughput operation (in_valid=out_ready=1 continuously) SHALL sustain one beat per cycle with no bubbles.

Reset
REQ-022 After reset: out_valid=0, out_fraction=0, skid entry empty, in_ready=1 in the first cycle after reset deasserts.
REQ-023 Reset mid-transfer SHALL drop all held beats; reset SHALL take priority over flush and the handshakes.
REQ-024 in_ready SHALL be 0 while reset is asserted.

Configuration
REQ-025 Macro RESULT_FRACTION_SELECT_SKID_EN defined: the stage SHALL have a 2-entry storage (main plus skid).
- in_ready = !skid_valid, driven from a flop with no combinational path from out_ready.
- A beat accepted while main is held and out_ready=0 SHALL go to skid.
- On the pop of main, skid SHALL move to main.
REQ-026 Macro RESULT_FRACTION_SELECT_SKID_EN undefined: the stage SHALL have a single register with in_ready = !out_valid || out_ready (combinational), and no skid storage.
REQ-027 Both builds SHALL produce identical output beat sequences for identical accepted inputs.

Verification
REQ-028 W=23, R=32: beats ZERO, QNAN, IRESULT (result=0x00555555) -> outputs 0x000000, 0x400000, 0x555555, each 1 cycle after acceptance.
REQ-029 RESULT with result=0x3FFFFFFF, and A with a=0xC00001 -> outputs 0x7FFFFF, 0x400001; codes 6 and 7 -> 0x000000.
REQ-030 Hold out_ready=0 for 3 cycles with in_valid=1: SKID_EN in_ready drops after 2 accepts; non-SKID after 1; out_fraction stays stable; on release, order is preserved.
REQ-031 Stream 100 random beats with in_valid=out_ready=1 -> 100 outputs on consecutive cycles, each matching the reference selection model.
REQ-032 Assert flush with 2 beats held and in_valid=1 -> out_valid=0 next cycle, all 3 beats lost, in_ready=1 the following cycle.
REQ-033 Assert reset with out_valid=1 -> out_valid=0 and out_fraction=0 next cycle; no stale beat emerges afterwards.
